branch_flow_ctrl: RTL and testbench
===================================

Name: branch_flow_ctrl

Overview:
Control-flow sequencer between ID and EX for the 16-bit pipelined CPU. It sequences conditional branches (BNE/BEQ/BGZ/BLZ) and register jumps (JPR/JRL) through three phases: hazard stall, resolution wait and mispredict flush. It produces the one-cycle update strobes for the BTB / 2-bit-counter predictor and keeps saturating branch/mispredict statistics. It replaces the ad-hoc count_B/count_J stall counters.

Parameters:
WORD_SIZE, 16, datapath and PC width
IDX_W, 8, predictor/BTB index width (index = PC[IDX_W-1:0])
HAZ_LIMIT, 3, max hazard-stall cycles before forced release
FLUSH_CYCLES, 1, flush/bubble cycles after a mispredict (1..3)
RESOLVE_TIMEOUT, 8, max cycles in RESOLVE before error abort

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_is_branch  in  1  ID instruction is BNE/BEQ/BGZ/BLZ
id_is_jreg  in  1  ID instruction is JPR/JRL
id_hazard  in  1  ID source register matches an in-flight writer (from hazard checker)
ex_resolve_valid  in  1  EX resolves the tracked control instruction this cycle
ex_mispredict  in  1  predicted next PC != correct PC (qualified by ex_resolve_valid)
ex_taken  in  1  branch/jump actually taken
ex_pc  in  WORD_SIZE  PC of the resolving instruction
ex_target  in  WORD_SIZE  taken-target address
stall_if  out  1  hold PC and IF/ID
stall_id  out  1  hold ID, insert bubble into ID/EX
flush_ifid  out  1  squash IF/ID contents
pred_upd_valid  out  1  one-cycle predictor counter update strobe
pred_upd_index  out  IDX_W  counter/BTB index to update
pred_upd_taken  out  1  direction for the saturating counter
btb_wr_en  out  1  one-cycle BTB target write strobe
btb_wr_target  out  WORD_SIZE  BTB write data
branch_cnt  out  16  saturating count of resolved control instructions
mispred_cnt  out  16  saturating count of mispredicts
err  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all counters and registered outputs 0; err=0.
- States: IDLE, HAZ_WAIT, RESOLVE, FLUSH.
- ctl = id_valid & (id_is_branch | id_is_jreg).
- IDLE:
  - ctl & id_hazard: go to HAZ_WAIT, haz_cnt=1. stall_if/stall_id are asserted combinationally in this same cycle.
  - ctl & !id_hazard: go to RESOLVE, to_cnt=0. No stall.
- HAZ_WAIT: stall_if=stall_id=1.
  - Each cycle: if !id_hazard or haz_cnt==HAZ_LIMIT, release (no stall in that cycle) and go to RESOLVE. Otherwise haz_cnt++.
- RESOLVE: tracks exactly one control instruction.
  - A further ctl in ID stalls (stall_if=stall_id=1) until resolution.
  - On ex_resolve_valid: branch_cnt+1 (saturates at 16'hFFFF).
    - Mispredict: mispred_cnt+1 (saturating); go to FLUSH with fl_cnt=FLUSH_CYCLES.
    - No mispredict: go to IDLE.
  - Otherwise to_cnt++. When to_cnt reaches RESOLVE_TIMEOUT: err=1, go to IDLE, no update strobe.
- FLUSH: flush_ifid=1 and stall_id=1 (bubble) for FLUSH_CYCLES cycles, then IDLE. A ctl in ID during FLUSH is squashed and not tracked.
- Update strobes (registered, the cycle after ex_resolve_valid is accepted in RESOLVE):
  - pred_upd_valid=1 only for id_is_branch-tracked instructions.
  - pred_upd_index=ex_pc[IDX_W-1:0]; pred_upd_taken=ex_taken.
  - btb_wr_en=1 iff tracked branch & ex_taken; btb_wr_target=ex_target.
  - JPR/JRL never update the predictor.
  - Strobes are 1 cycle and otherwise 0.
- ex_resolve_valid outside RESOLVE: ignored, err=1.
- ex_mispredict/ex_taken are don't-care when ex_resolve_valid=0.
- Tracked kind (branch vs jreg) is latched on entry to HAZ_WAIT or RESOLVE.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, HAZ_WAIT=2'd1, RESOLVE=2'd2, FLUSH=2'd3) and WORD_SIZE, taken from the existing opcodes include.
- One sub-module: sat_counter16 (enable, async clear, saturates at 16'hFFFF), instantiated twice.

Test Plan:
- BEQ at PC 16'h0012, no hazard; resolve at +2 cycles with taken=1, mispredict=1, target 16'h0020 -> FLUSH 1 cycle (flush_ifid=1); next cycle pred_upd_valid=1, index=8'h12, taken=1, btb_wr_en=1, target=16'h0020; mispred_cnt=1, branch_cnt=1.
- BNE with id_hazard held 5 cycles, HAZ_LIMIT=3 -> stall_if high exactly 3 cycles, then RESOLVE.
- JPR with hazard clearing after 1 cycle, resolved correctly -> 1 stall cycle; pred_upd_valid and btb_wr_en stay 0; branch_cnt=1.
- Second BLZ arrives in ID while the first is in RESOLVE -> stall_id=1 until ex_resolve_valid; then the second is tracked without a bubble.
- No ex_resolve_valid for 8 cycles in RESOLVE -> err=1, IDLE, no strobe. Spurious ex_resolve_valid in IDLE -> err=1.
- reset_n low mid-FLUSH -> flush_ifid and stall outputs drop to 0 immediately (asynchronously); counters=0; state=IDLE.

Source files
------------

// File: rtl/branch_flow_ctrl_pkg.sv
// Shared definitions for the ID/EX control-flow sequencer: FSM state encoding
// and the CPU word size.
package branch_flow_ctrl_pkg;

    localparam int WORD_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HAZ_WAIT = 2'd1,
        RESOLVE  = 2'd2,
        FLUSH    = 2'd3
    } state_t;

endpackage

// File: rtl/branch_flow_ctrl_sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/branch_flow_ctrl.sv
// ID/EX control-flow sequencer: hazard stall, resolution wait and mispredict
// flush for branches and register jumps, plus predictor/BTB update strobes.
module branch_flow_ctrl #(
    parameter int WORD_SIZE       = branch_flow_ctrl_pkg::WORD_SIZE,
    parameter int IDX_W           = 8,
    parameter int HAZ_LIMIT       = 3,
    parameter int FLUSH_CYCLES    = 1,
    parameter int RESOLVE_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 id_valid,
    input  logic                 id_is_branch,
    input  logic                 id_is_jreg,
    input  logic                 id_hazard,
    input  logic                 ex_resolve_valid,
    input  logic                 ex_mispredict,
    input  logic                 ex_taken,
    input  logic [WORD_SIZE-1:0] ex_pc,
    input  logic [WORD_SIZE-1:0] ex_target,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 flush_ifid,
    output logic                 pred_upd_valid,
    output logic [IDX_W-1:0]     pred_upd_index,
    output logic                 pred_upd_taken,
    output logic                 btb_wr_en,
    output logic [WORD_SIZE-1:0] btb_wr_target,
    output logic [15:0]          branch_cnt,
    output logic [15:0]          mispred_cnt,
    output logic                 err
);
    import branch_flow_ctrl_pkg::*;

    localparam int HAZ_W = $clog2(HAZ_LIMIT + 1);
    localparam int TO_W  = $clog2(RESOLVE_TIMEOUT + 1);
    localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);

    localparam logic [HAZ_W-1:0] HAZ_MAX = HAZ_W'(HAZ_LIMIT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(RESOLVE_TIMEOUT - 1);
    localparam logic [FL_W-1:0]  FL_INIT = FL_W'(FLUSH_CYCLES);

    state_t            state_reg;
    logic [HAZ_W-1:0]  haz_cnt_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic [FL_W-1:0]   fl_cnt_reg;
    logic              kind_branch_reg;

    logic ctl;
    logic resolve_ok;
    logic haz_release;
    logic to_expire;
    logic unused_pc_bits;

    assign ctl         = id_valid & (id_is_branch | id_is_jreg);
    assign resolve_ok  = (state_reg == RESOLVE) & ex_resolve_valid;
    assign haz_release = !id_hazard || (haz_cnt_reg == HAZ_MAX);
    assign to_expire   = (state_reg == RESOLVE) && !ex_resolve_valid && (to_cnt_reg == TO_LAST);

    // Only the low PC bits form the predictor index.
    assign unused_pc_bits = ^ex_pc;

    // Stalls react to ID in the same cycle, so they are decoded from state and inputs.
    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        flush_ifid = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ctl && id_hazard) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                end
            end
            HAZ_WAIT: begin
                if (!haz_release) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                end
            end
            RESOLVE: begin
                // Hold a second control instruction in ID, including the resolve cycle.
                if (ctl) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                end
            end
            FLUSH: begin
                stall_id   = 1'b1;
                flush_ifid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            haz_cnt_reg     <= '0;
            to_cnt_reg      <= '0;
            fl_cnt_reg      <= '0;
            kind_branch_reg <= 1'b0;
            err             <= 1'b0;
            pred_upd_valid  <= 1'b0;
            pred_upd_index  <= '0;
            pred_upd_taken  <= 1'b0;
            btb_wr_en       <= 1'b0;
            btb_wr_target   <= '0;
        end else begin
            pred_upd_valid <= resolve_ok & kind_branch_reg;
            pred_upd_index <= resolve_ok ? ex_pc[IDX_W-1:0] : '0;
            pred_upd_taken <= resolve_ok & ex_taken;
            btb_wr_en      <= resolve_ok & kind_branch_reg & ex_taken;
            btb_wr_target  <= resolve_ok ? ex_target : '0;

            if ((ex_resolve_valid && (state_reg != RESOLVE)) || to_expire) begin
                err <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (ctl) begin
                        kind_branch_reg <= id_is_branch;
                        if (id_hazard) begin
                            state_reg   <= HAZ_WAIT;
                            haz_cnt_reg <= HAZ_W'(1);
                        end else begin
                            state_reg  <= RESOLVE;
                            to_cnt_reg <= '0;
                        end
                    end
                end
                HAZ_WAIT: begin
                    if (haz_release) begin
                        state_reg  <= RESOLVE;
                        to_cnt_reg <= '0;
                    end else begin
                        haz_cnt_reg <= haz_cnt_reg + 1'b1;
                    end
                end
                RESOLVE: begin
                    if (ex_resolve_valid) begin
                        if (ex_mispredict) begin
                            state_reg  <= FLUSH;
                            fl_cnt_reg <= FL_INIT;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (to_cnt_reg == TO_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                FLUSH: begin
                    if (fl_cnt_reg <= FL_W'(1)) begin
                        state_reg <= IDLE;
                    end else begin
                        fl_cnt_reg <= fl_cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    sat_counter16 u_branch_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (resolve_ok),
        .count   (branch_cnt)
    );

    sat_counter16 u_mispred_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (resolve_ok & ex_mispredict),
        .count   (mispred_cnt)
    );

endmodule

// File: tb/tb_branch_flow_ctrl.sv
// Directed bench for branch_flow_ctrl: stimulus pushes expected stall/flush and
// update-strobe records into queues, a negedge monitor pops and compares them.
module tb_branch_flow_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        id_valid = 1'b0, id_is_branch = 1'b0, id_is_jreg = 1'b0, id_hazard = 1'b0;
    logic        ex_resolve_valid = 1'b0, ex_mispredict = 1'b0, ex_taken = 1'b0;
    logic [15:0] ex_pc = '0, ex_target = '0;
    logic        stall_if, stall_id, flush_ifid;
    logic        pred_upd_valid, pred_upd_taken, btb_wr_en, err;
    logic [7:0]  pred_upd_index;
    logic [15:0] btb_wr_target, branch_cnt, mispred_cnt;

    branch_flow_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .id_valid         (id_valid),
        .id_is_branch     (id_is_branch),
        .id_is_jreg       (id_is_jreg),
        .id_hazard        (id_hazard),
        .ex_resolve_valid (ex_resolve_valid),
        .ex_mispredict    (ex_mispredict),
        .ex_taken         (ex_taken),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .stall_if         (stall_if),
        .stall_id         (stall_id),
        .flush_ifid       (flush_ifid),
        .pred_upd_valid   (pred_upd_valid),
        .pred_upd_index   (pred_upd_index),
        .pred_upd_taken   (pred_upd_taken),
        .btb_wr_en        (btb_wr_en),
        .btb_wr_target    (btb_wr_target),
        .branch_cnt       (branch_cnt),
        .mispred_cnt      (mispred_cnt),
        .err              (err)
    );

    always #5 clk = ~clk;

    // Input bundle {valid, branch, jreg, hazard, resolve, mispredict, taken}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] V_BR = 7'b1100000;
    localparam logic [6:0] V_JR = 7'b1010000;
    localparam logic [6:0] HZ   = 7'b0001000;
    localparam logic [6:0] RV   = 7'b0000100;
    localparam logic [6:0] MP   = 7'b0000010;
    localparam logic [6:0] TK   = 7'b0000001;
    // Expected {stall_if, stall_id, flush_ifid}
    localparam logic [2:0] S_NONE  = 3'b000;
    localparam logic [2:0] S_STALL = 3'b110;
    localparam logic [2:0] S_FLUSH = 3'b011;

    typedef struct {
        logic [7:0]  idx;
        logic        tk;
        logic        bw;
        logic [15:0] tgt;
        int          cyc;
    } upd_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [2:0] ctl_q[$];
    upd_t       upd_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [6:0] in, input logic [15:0] pc, input logic [15:0] tg,
                        input logic [2:0] exp);
        @(posedge clk);
        #1;
        {id_valid, id_is_branch, id_is_jreg, id_hazard,
         ex_resolve_valid, ex_mispredict, ex_taken} = in;
        ex_pc     = pc;
        ex_target = tg;
        ctl_q.push_back(exp);
    endtask

    // Strobe is due on the cycle after the resolve step just issued.
    task automatic push_upd(input logic [7:0] idx, input logic tk, input logic bw,
                            input logic [15:0] tgt);
        upd_t u;
        u.idx = idx; u.tk = tk; u.bw = bw; u.tgt = tgt; u.cyc = cyc + 1;
        upd_q.push_back(u);
    endtask

    always @(negedge clk) begin : monitor
        logic [2:0] e;
        upd_t       u;
        if (reset_n) begin
            if (ctl_q.size() > 0) begin
                e = ctl_q.pop_front();
                chk($sformatf("stall_flush@%0d", cyc), {29'd0, stall_if, stall_id, flush_ifid}, {29'd0, e});
            end
            if (upd_q.size() > 0 && upd_q[0].cyc < cyc) begin
                u = upd_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_strobe: got none expected idx %0h at cycle %0d", u.idx, u.cyc);
            end
            if (pred_upd_valid || btb_wr_en) begin
                if (upd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe@%0d: got valid=%0b btb=%0b expected none",
                             cyc, pred_upd_valid, btb_wr_en);
                end else begin
                    u = upd_q.pop_front();
                    chk("upd_cycle", cyc, u.cyc);
                    chk("pred_upd_valid", {31'd0, pred_upd_valid}, 32'd1);
                    chk("pred_upd_index", {24'd0, pred_upd_index}, {24'd0, u.idx});
                    chk("pred_upd_taken", {31'd0, pred_upd_taken}, {31'd0, u.tk});
                    chk("btb_wr_en", {31'd0, btb_wr_en}, {31'd0, u.bw});
                    if (u.bw) chk("btb_wr_target", {16'd0, btb_wr_target}, {16'd0, u.tgt});
                    $display("update cycle %0d idx=%02h taken=%0b btb=%0b target=%04h",
                             cyc, pred_upd_index, pred_upd_taken, btb_wr_en, btb_wr_target);
                end
            end
        end
    end

    task automatic chk_cnt(input logic [15:0] b, input logic [15:0] m, input logic e);
        @(negedge clk);
        chk("branch_cnt", {16'd0, branch_cnt}, {16'd0, b});
        chk("mispred_cnt", {16'd0, mispred_cnt}, {16'd0, m});
        chk("err", {31'd0, err}, {31'd0, e});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_stall_if", {31'd0, stall_if}, 32'd0);
        chk("rst_stall_id", {31'd0, stall_id}, 32'd0);
        chk("rst_flush", {31'd0, flush_ifid}, 32'd0);
        chk("rst_pred_valid", {31'd0, pred_upd_valid}, 32'd0);
        chk("rst_btb_en", {31'd0, btb_wr_en}, 32'd0);
        chk("rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
        chk("rst_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // BEQ @0012, mispredicted taken to 0020 -> one flush cycle
        step(V_BR, 16'h0012, 16'h0000, S_NONE);
        step(NONE, 16'h0000, 16'h0000, S_NONE);
        step(RV | MP | TK, 16'h0012, 16'h0020, S_NONE);
        push_upd(8'h12, 1'b1, 1'b1, 16'h0020);
        step(NONE, 16'h0000, 16'h0000, S_FLUSH);
        step(NONE, 16'h0000, 16'h0000, S_NONE);
        chk_cnt(16'd1, 16'd1, 1'b0);

        // BNE with hazard held 5 cycles: stall capped at 3 cycles
        step(V_BR | HZ, 16'h0000, 16'h0000, S_STALL);
        step(V_BR | HZ, 16'h0000, 16'h0000, S_STALL);
        step(V_BR | HZ, 16'h0000, 16'h0000, S_STALL);
        step(V_BR | HZ, 16'h0000, 16'h0000, S_NONE);
        step(HZ, 16'h0000, 16'h0000, S_NONE);
        step(RV, 16'h0034, 16'h0040, S_NONE);
        push_upd(8'h34, 1'b0, 1'b0, 16'h0000);
        step(NONE, 16'h0000, 16'h0000, S_NONE);
        chk_cnt(16'd2, 16'd1, 1'b0);

        // JPR, hazard clears after 1 cycle, taken: no predictor update
        step(V_JR | HZ, 16'h0000, 16'h0000, S_STALL);
        step(V_JR, 16'h0000, 16'h0000, S_NONE);
        step(RV | TK, 16'h0050, 16'h0060, S_NONE);
        step(NONE, 16'h0000, 16'h0000, S_NONE);
        chk_cnt(16'd3, 16'd1, 1'b0);

        // Back-to-back BLZ: second held until the first resolves
        step(V_BR, 16'h0000, 16'h0000, S_NONE);
        step(V_BR, 16'h0000, 16'h0000, S_STALL);
        step(V_BR, 16'h0000, 16'h0000, S_STALL);
        step(V_BR | RV | TK, 16'h0070, 16'h0080, S_STALL);
        push_upd(8'h70, 1'b1, 1'b1, 16'h0080);
        step(V_BR, 16'h0000, 16'h0000, S_NONE);
        step(RV, 16'h0074, 16'h0000, S_NONE);
        push_upd(8'h74, 1'b0, 1'b0, 16'h0000);
        step(NONE, 16'h0000, 16'h0000, S_NONE);
        chk_cnt(16'd5, 16'd1, 1'b0);

        // Resolve timeout: err after 8 RESOLVE cycles, back to IDLE
        step(V_BR, 16'h0000, 16'h0000, S_NONE);
        repeat (7) step(NONE, 16'h0000, 16'h0000, S_NONE);
        chk_cnt(16'd5, 16'd1, 1'b0);
        step(NONE, 16'h0000, 16'h0000, S_NONE);
        step(V_BR, 16'h0000, 16'h0000, S_NONE);
        chk_cnt(16'd5, 16'd1, 1'b1);

        // Spurious resolve in IDLE after a fresh reset
        {id_valid, id_is_branch, id_is_jreg, id_hazard,
         ex_resolve_valid, ex_mispredict, ex_taken} = NONE;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk_cnt(16'd0, 16'd0, 1'b0);
        step(RV | TK, 16'h0099, 16'h0011, S_NONE);
        step(NONE, 16'h0000, 16'h0000, S_NONE);
        chk_cnt(16'd0, 16'd0, 1'b1);

        // Asynchronous reset in the middle of FLUSH
        step(V_BR, 16'h0000, 16'h0000, S_NONE);
        step(RV | MP | TK, 16'h00A0, 16'h00B0, S_NONE);
        push_upd(8'hA0, 1'b1, 1'b1, 16'h00B0);
        step(NONE, 16'h0000, 16'h0000, S_FLUSH);
        chk_cnt(16'd1, 16'd1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_flush", {31'd0, flush_ifid}, 32'd0);
        chk("arst_stall_id", {31'd0, stall_id}, 32'd0);
        chk("arst_stall_if", {31'd0, stall_if}, 32'd0);
        chk("arst_pred_valid", {31'd0, pred_upd_valid}, 32'd0);
        chk("arst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
        chk("arst_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        // A ctl without hazard in IDLE passes straight through, proving FLUSH was left
        step(V_BR, 16'h0000, 16'h0000, S_NONE);
        step(RV, 16'h00C1, 16'h0000, S_NONE);
        push_upd(8'hC1, 1'b0, 1'b0, 16'h0000);
        step(NONE, 16'h0000, 16'h0000, S_NONE);
        chk_cnt(16'd1, 16'd0, 1'b0);

        repeat (2) @(negedge clk);
        chk("ctl_queue_empty", ctl_q.size(), 32'd0);
        chk("upd_queue_empty", upd_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
